// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port RAM.
// Port 0 is normally the CPU and port 1 a secondary master (DMA/debug loader).
// Ownership is granted one cycle after a request. Port 0 wins the first tie
// after reset. A locked owner keeps the RAM for at most MAX_LOCK consecutive
// cycles while the other port waits.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   reqN/lockN/weN/addrN/wdataN  per-port request, burst lock, write enable,
//                                address and write data (N = 0, 1)
//   gntN                         registered grant, never both high
//   rvalidN                      1-cycle pulse: rdata holds port N's read result
//   mem_addr/mem_wdata/mem_we    RAM command, zero while no access is in flight
//   mem_rdata                    RAM read data, valid 1 cycle after the address
//   rdata                        mem_rdata passed through to both ports
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module mem_arbiter #(
  parameter int ADDR_W   = `ADDR_SIZE,
  parameter int WORD_W   = `WORD_SIZE,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              lock0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WORD_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              lock1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           r_state, w_next;
  logic             r_last_owner;
  logic [CNT_W-1:0] r_lock_cnt, w_lock_nxt;
  logic             r_rvalid0, r_rvalid1;
  logic             w_acc0, w_acc1;
  logic             w_req_own, w_req_oth, w_lock_own;
  state_t           w_oth_state;

  // Owner-relative view so both OWN states share one set of transition rules.
  always_comb begin
    w_req_own   = 1'b0;
    w_req_oth   = 1'b0;
    w_lock_own  = 1'b0;
    w_oth_state = IDLE;
    if (r_state == OWN0) begin
      w_req_own   = req0;
      w_req_oth   = req1;
      w_lock_own  = lock0;
      w_oth_state = OWN1;
    end else if (r_state == OWN1) begin
      w_req_own   = req1;
      w_req_oth   = req0;
      w_lock_own  = lock1;
      w_oth_state = OWN0;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_lock_nxt = '0;
    case (r_state)
      IDLE: begin
        if (req0 && req1)  w_next = r_last_owner ? OWN0 : OWN1;
        else if (req0)     w_next = OWN0;
        else if (req1)     w_next = OWN1;
      end
      OWN0, OWN1: begin
        if (!w_req_own) begin
          w_next = w_req_oth ? w_oth_state : IDLE;
        end else if (w_req_oth) begin
          // Lock extends the turn until the counter reaches its last value.
          if (w_lock_own && (r_lock_cnt != LOCK_LAST)) begin
            w_lock_nxt = r_lock_cnt + 1'b1;
          end else begin
            w_next = w_oth_state;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_lock_cnt   <= '0;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_lock_cnt <= w_lock_nxt;
      if (w_next == OWN0) r_last_owner <= 1'b0;
      else if (w_next == OWN1) r_last_owner <= 1'b1;
      r_rvalid0 <= w_acc0 && !we0;
      r_rvalid1 <= w_acc1 && !we1;
    end
  end

  assign w_acc0 = (r_state == OWN0) && req0;
  assign w_acc1 = (r_state == OWN1) && req1;

  assign gnt0    = (r_state == OWN0);
  assign gnt1    = (r_state == OWN1);
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = mem_rdata;

  assign mem_addr  = w_acc0 ? addr0  : (w_acc1 ? addr1  : '0);
  assign mem_wdata = w_acc0 ? wdata0 : (w_acc1 ? wdata1 : '0);
  // Writes are suppressed while reset is asserted.
  assign mem_we    = !rst && ((w_acc0 && we0) || (w_acc1 && we1));

endmodule
